// File: rtl/scl_ddr_gen_pkg.sv
// Shared i3c DDR definitions: SCL generator state encoding and default timing.
package scl_ddr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } scl_state_e;

    // Half-periods are in system clock cycles; frame length is in SCL edges.
    localparam int DEF_PP_HALF    = 2;
    localparam int DEF_OD_HALF    = 10;
    localparam int DEF_FRAME_BITS = 20;

endpackage

// File: rtl/scl_ddr_gen_edge_counter.sv
// DDR edge counter: counts SCL strobes (both edges) and flags the last edge
// of each frame. The frame length may change at any time; a count already at
// or past the new last edge wraps on the next strobe.
module ddr_edge_counter
    import scl_ddr_gen_pkg::*;
#(
    parameter int BIT_W      = 5,
    parameter int FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_n,
    input  logic             i_strobe,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [BIT_W-1:0] i_frame_len,
    output logic [BIT_W-1:0] o_count,
    output logic             o_frame_done
);

    logic [BIT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [BIT_W-1:0] last_edge;

    // Next count / frame-done; a zero frame length selects the default length.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d   = count_q;
        done_d    = 1'b0;
        last_edge = (i_frame_len == '0) ? BIT_W'(FRAME_BITS - 1)
                                        : i_frame_len - BIT_W'(1);
        if (i_clear || !i_en) begin
            count_d = '0;
        end else if (i_strobe) begin
            if (count_q >= last_edge) begin
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + BIT_W'(1);
            end
        end
    end

    // Count and frame-done registers.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign o_count      = count_q;
    assign o_frame_done = done_q;

endmodule

// File: rtl/scl_ddr_gen.sv
// I3C DDR SCL generator: produces SCL as registered data with one-cycle edge
// strobes, push-pull or open-drain half-periods, stall/idle control, and an
// edge counter that marks frame boundaries.
module scl_ddr_gen
    import scl_ddr_gen_pkg::*;
#(
    parameter int PP_HALF    = DEF_PP_HALF,
    parameter int OD_HALF    = DEF_OD_HALF,
    parameter int HALF_W     = 8,
    parameter int BIT_W      = 5,
    parameter int FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_pp_od,
    input  logic             i_stall,
    input  logic             i_idle,
    input  logic             i_bitcnt_en,
    input  logic [BIT_W-1:0] i_frame_len,
    output logic             o_scl,
    output logic             o_scl_pos_edge,
    output logic             o_scl_neg_edge,
    output logic [BIT_W-1:0] o_bit_count,
    output logic             o_frame_done,
    output logic             o_busy
);

    scl_state_e        state_q, state_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic [HALF_W-1:0] len_q, len_d;     // length of the half in progress
    logic              scl_q, scl_d;
    logic              pos_q, pos_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              count_stb;        // strobe that the edge counter may count
    logic [HALF_W-1:0] half_sel;
    logic              half_end;

    assign half_sel = i_pp_od ? HALF_W'(PP_HALF) : HALF_W'(OD_HALF);
    assign half_end = (cnt_q == len_q - HALF_W'(1));

    // Next state, half counter, SCL level and strobes; idle beats stall beats run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        scl_d     = scl_q;
        pos_d     = 1'b0;
        neg_d     = 1'b0;
        count_stb = 1'b0;
        if (i_idle) begin
            // The release strobe is not a data edge, so it is never counted.
            state_d = IDLE;
            cnt_d   = '0;
            scl_d   = 1'b1;
            pos_d   = ~scl_q;
        end else if (!i_stall) begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (i_en) begin
                        state_d   = LOW;
                        scl_d     = 1'b0;
                        neg_d     = 1'b1;
                        count_stb = 1'b1;
                        len_d     = half_sel;
                    end
                end
                LOW: begin
                    if (half_end) begin
                        state_d   = HIGH;
                        cnt_d     = '0;
                        scl_d     = 1'b1;
                        pos_d     = 1'b1;
                        count_stb = 1'b1;
                        len_d     = half_sel;
                    end else begin
                        cnt_d = cnt_q + HALF_W'(1);
                    end
                end
                HIGH: begin
                    if (half_end) begin
                        cnt_d = '0;
                        if (i_en) begin
                            state_d   = LOW;
                            scl_d     = 1'b0;
                            neg_d     = 1'b1;
                            count_stb = 1'b1;
                            len_d     = half_sel;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + HALF_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    scl_d   = 1'b1;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset parks SCL high with no strobe.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= HALF_W'(PP_HALF);
            scl_q   <= 1'b1;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            scl_q   <= scl_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
        end
    end

    ddr_edge_counter #(
        .BIT_W      (BIT_W),
        .FRAME_BITS (FRAME_BITS)
    ) u_edge_counter (
        .i_sys_clk    (i_sys_clk),
        .i_rst_n      (i_rst_n),
        .i_strobe     (count_stb),
        .i_en         (i_bitcnt_en),
        .i_clear      (i_idle),
        .i_frame_len  (i_frame_len),
        .o_count      (o_bit_count),
        .o_frame_done (o_frame_done)
    );

    assign o_scl          = scl_q;
    assign o_scl_pos_edge = pos_q;
    assign o_scl_neg_edge = neg_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_scl_ddr_gen.sv
// Directed bench for scl_ddr_gen: inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_scl_ddr_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pp_od;
    logic       stall;
    logic       idle;
    logic       bitcnt_en;
    logic [4:0] frame_len;
    logic       scl;
    logic       pos;
    logic       neg;
    logic [4:0] bit_count;
    logic       frame_done;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    scl_ddr_gen dut (
        .i_sys_clk      (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .i_pp_od        (pp_od),
        .i_stall        (stall),
        .i_idle         (idle),
        .i_bitcnt_en    (bitcnt_en),
        .i_frame_len    (frame_len),
        .o_scl          (scl),
        .o_scl_pos_edge (pos),
        .o_scl_neg_edge (neg),
        .o_bit_count    (bit_count),
        .o_frame_done   (frame_done),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_scl, input int e_pos,
                             input int e_neg, input int e_cnt, input int e_done,
                             input int e_busy);
        check({tag, ".scl"},  int'(scl),        e_scl);
        check({tag, ".pos"},  int'(pos),        e_pos);
        check({tag, ".neg"},  int'(neg),        e_neg);
        check({tag, ".cnt"},  int'(bit_count),  e_cnt);
        check({tag, ".done"}, int'(frame_done), e_done);
        check({tag, ".busy"}, int'(busy),       e_busy);
    endtask

    initial begin
        int s;
        int stb;

        rst_n     = 1'b0;
        en        = 1'b0;
        pp_od     = 1'b1;
        stall     = 1'b0;
        idle      = 1'b0;
        bitcnt_en = 1'b0;
        frame_len = 5'd0;

        // Reset values.
        repeat (2) @(negedge clk);
        check_all("reset", 1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("idle_no_en", 1, 0, 0, 0, 0, 0);

        // Push-pull: period 4, first strobe neg one cycle after enable,
        // frame of 4 edges.
        en        = 1'b1;
        bitcnt_en = 1'b1;
        frame_len = 5'd4;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            s   = (k - 1) / 2 + 1;
            stb = ((k - 1) % 2 == 0) ? 1 : 0;
            check_all("pp_run", ((k - 1) / 2) % 2,
                      ((k - 1) % 4 == 2) ? 1 : 0,
                      ((k - 1) % 4 == 0) ? 1 : 0,
                      s % 4,
                      (stb == 1 && s % 4 == 0) ? 1 : 0, 1);
        end

        // Disable at end of high half: straight to IDLE, no strobe.
        en = 1'b0;
        @(negedge clk);
        check_all("stop_high", 1, 0, 0, 2, 0, 0);
        @(negedge clk);
        check_all("stay_idle", 1, 0, 0, 2, 0, 0);

        // Counter held at zero while counting is disabled.
        bitcnt_en = 1'b0;
        @(negedge clk);
        check("cnt_disabled", int'(bit_count), 0);

        // Open-drain: period 20, default frame of 20 edges; switch to
        // push-pull in the middle of a low half.
        pp_od     = 1'b0;
        frame_len = 5'd0;
        bitcnt_en = 1'b1;
        en        = 1'b1;
        for (int k = 1; k <= 210; k++) begin
            @(negedge clk);
            s   = (k - 1) / 10 + 1;
            stb = ((k - 1) % 10 == 0) ? 1 : 0;
            check_all("od_run", ((k - 1) / 10) % 2,
                      ((k - 1) % 20 == 10) ? 1 : 0,
                      ((k - 1) % 20 == 0) ? 1 : 0,
                      s % 20,
                      (stb == 1 && s % 20 == 0) ? 1 : 0, 1);
            if (k == 203) pp_od = 1'b1;
        end
        @(negedge clk);  // 211: high half now push-pull length
        check_all("mode_sw_pos", 1, 1, 0, 2, 0, 1);
        @(negedge clk);
        check_all("mode_sw_hi", 1, 0, 0, 2, 0, 1);
        @(negedge clk);
        check_all("mode_sw_neg", 0, 0, 1, 3, 0, 1);
        @(negedge clk);  // low half, count 1
        check_all("pre_stall", 0, 0, 0, 3, 0, 1);

        // Stall 7 clocks at half-count 1 in LOW: low lasts 2+7 clocks.
        stall = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check_all("stall", 0, 0, 0, 3, 0, 1);
        end
        stall = 1'b0;
        @(negedge clk);
        check_all("stall_rel", 1, 1, 0, 4, 0, 1);

        // Shrink frame below current count: wraps on next strobe.
        frame_len = 5'd3;
        @(negedge clk);
        check_all("len_hold", 1, 0, 0, 4, 0, 1);
        @(negedge clk);
        check_all("len_shrink", 0, 0, 1, 0, 1, 1);

        // Into open-drain, reach LOW with half-count 9, then force idle.
        pp_od = 1'b0;
        @(negedge clk);
        check_all("pp_low2", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check_all("od_pos", 1, 1, 0, 1, 0, 1);
        repeat (9) @(negedge clk);
        @(negedge clk);
        check_all("od_neg", 0, 0, 1, 2, 0, 1);
        repeat (9) @(negedge clk);
        idle = 1'b1;
        @(negedge clk);
        check_all("idle_force", 1, 1, 0, 0, 0, 0);
        idle = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        check_all("idle_hold", 1, 0, 0, 0, 0, 0);

        // Restart in push-pull, then reset in the middle of HIGH.
        pp_od = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check_all("restart_neg", 0, 0, 1, 1, 0, 1);
        @(negedge clk);
        check_all("restart_low", 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        check_all("restart_pos", 1, 1, 0, 2, 0, 1);
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 1, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_all("rst_held", 1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("rst_restart", 0, 0, 1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scl_ddr_gen.md
SCL_DDR_GEN -- requirements
Module: scl_ddr_gen

Interface
REQ-001 SHALL have parameter PP_HALF, default 2, meaning push-pull SCL half-period in i_sys_clk cycles (minimum 1).
REQ-002 SHALL have parameter OD_HALF, default 10, meaning open-drain SCL half-period in i_sys_clk cycles (minimum 1).
REQ-003 SHALL have parameter HALF_W, default 8, meaning half-period counter width.
REQ-004 SHALL have parameter BIT_W, default 5, meaning edge counter and frame-length width.
REQ-005 SHALL have parameter FRAME_BITS, default 20, meaning default DDR word length in SCL edges.
REQ-006 SHALL have ports: i_sys_clk in 1, system clock; i_rst_n in 1, reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have i_en in 1, run SCL; i_pp_od in 1, 1 = push-pull timing, 0 = open-drain timing.
REQ-008 SHALL have i_stall in 1, freeze SCL; i_idle in 1, force SCL high and idle.
REQ-009 SHALL have i_bitcnt_en in 1, enable edge counting; i_frame_len in BIT_W, edges per frame (0 = FRAME_BITS).
REQ-010 SHALL have o_scl out 1; o_scl_pos_edge out 1; o_scl_neg_edge out 1; o_bit_count out BIT_W; o_frame_done out 1; o_busy out 1.

Function
REQ-011 SHALL implement FSM states IDLE, LOW, HIGH; o_scl = 0 only in LOW; o_busy = 1 in LOW and HIGH.
REQ-012 SHALL give priority: reset > i_idle > i_stall > normal operation.
REQ-013 IDLE with i_en=1 and i_idle=0 SHALL go to LOW next cycle, o_scl_neg_edge pulsed in that cycle.
REQ-014 In LOW/HIGH, the half counter SHALL count 0..H-1; at H-1 the state toggles and the counter clears.
REQ-015 H SHALL be PP_HALF or OD_HALF, selected from i_pp_od sampled at each edge; mid-half changes take effect at the next half.
REQ-016 A LOW->HIGH toggle SHALL pulse o_scl_pos_edge; HIGH->LOW SHALL pulse o_scl_neg_edge; each pulse is one cycle, coincident with the o_scl change.
REQ-017 In HIGH at terminal count with i_en=0, the FSM SHALL go to IDLE with no strobe; in LOW, i_en=0 completes the low half first.
REQ-018 While i_stall=1, the half counter SHALL freeze, the level hold, and no strobes occur; on release the counter resumes from the frozen value.
REQ-019 i_idle=1 SHALL force IDLE next cycle from any state; if o_scl was 0, o_scl_pos_edge pulses once; the half counter and o_bit_count clear.
REQ-020 o_bit_count SHALL increment on every strobe, both edges, while i_bitcnt_en=1, and hold 0 while i_bitcnt_en=0.
REQ-021 When a strobe arrives with o_bit_count = L-1 (L = i_frame_len, or FRAME_BITS if 0), o_bit_count SHALL wrap to 0 and o_frame_done pulse one cycle.
REQ-022 i_frame_len changes SHALL take effect immediately; a count already >= L-1 wraps on the next strobe.
REQ-023 The strobe raised by i_idle SHALL NOT be counted and SHALL NOT raise o_frame_done.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 Reset SHALL give: state IDLE, o_scl=1, strobes=0, o_bit_count=0, o_frame_done=0, o_busy=0, half counter=0.
REQ-026 Reset asserted mid-transfer SHALL drive o_scl high asynchronously with no strobe; operation restarts only via REQ-013.

Structure
REQ-027 State enum and default half-period constants SHALL live in the shared i3c DDR package.
REQ-028 The edge counter SHALL be a sub-module, ddr_edge_counter (strobes in; count and frame_done out).
REQ-029 SHALL be synthesisable with no latches and no derived clocks; SCL is data, not a clock.

Verification
REQ-030 Defaults, i_en=1, i_pp_od=1 -> o_scl period 4 clocks; strobes alternate; first strobe is neg, one cycle after i_en.
REQ-031 i_pp_od=0 -> period 20 clocks; toggling i_pp_od mid-low -> the current half keeps its old length, the next uses the new one.
REQ-032 i_bitcnt_en=1, i_frame_len=0 -> o_frame_done on every 20th strobe, o_bit_count 19->0; i_frame_len=4 -> done every 4th strobe.
REQ-033 i_stall=1 for 7 clocks at half-count 1 in LOW -> low phase lasts PP_HALF+7 clocks, no strobe during the stall.
REQ-034 i_idle=1 while LOW with count 9 -> one pos strobe, o_scl=1, o_bit_count=0, no frame_done, o_busy=0.
REQ-035 i_rst_n low mid-HIGH, held 3 clocks -> all outputs at reset values immediately; after release SCL restarts with a neg strobe.
